// File: rtl/emif_axi_mm_credit_gate_if.sv
// AXI-MM bundle between the AFU, the credit gate and one EMIF memory-subsystem channel.
// The emif modport is the memory side: it owns clk/rst_n and the ready/response signals.
interface ofs_fim_emif_axi_mm_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int USER_W = 4
);
  logic                  clk;
  logic                  rst_n;
  logic                  awvalid;
  logic                  awready;
  logic [ID_W-1:0]       awid;
  logic [ADDR_W-1:0]     awaddr;
  logic [7:0]            awlen;
  logic [USER_W-1:0]     awuser;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  wlast;
  logic                  bvalid;
  logic                  bready;
  logic [ID_W-1:0]       bid;
  logic [1:0]            bresp;
  logic                  arvalid;
  logic                  arready;
  logic [ID_W-1:0]       arid;
  logic [ADDR_W-1:0]     araddr;
  logic [7:0]            arlen;
  logic [USER_W-1:0]     aruser;
  logic                  rvalid;
  logic                  rready;
  logic [ID_W-1:0]       rid;
  logic [DATA_W-1:0]     rdata;
  logic [1:0]            rresp;
  logic                  rlast;

  modport emif (
    output clk, rst_n, awready, wready, bvalid, bid, bresp, arready,
           rvalid, rid, rdata, rresp, rlast,
    input  awvalid, awid, awaddr, awlen, awuser, wvalid, wdata, wstrb, wlast,
           bready, arvalid, arid, araddr, arlen, aruser, rready
  );

  modport user (
    input  clk, rst_n, awready, wready, bvalid, bid, bresp, arready,
           rvalid, rid, rdata, rresp, rlast,
    output awvalid, awid, awaddr, awlen, awuser, wvalid, wdata, wstrb, wlast,
           bready, arvalid, arid, araddr, arlen, aruser, rready
  );
endinterface

// File: rtl/emif_axi_mm_credit_gate.sv
// Credit gate in front of one EMIF channel: bounds outstanding AR/AW bursts and provides a
// quiesce/drain handshake. Stall statistics exist only when OFS_MEM_CREDIT_GATE_STATS_EN is defined.
module emif_axi_mm_credit_gate #(
  parameter int MAX_RD_OUTSTANDING = 64,
  parameter int MAX_WR_OUTSTANDING = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  ofs_fim_emif_axi_mm_if.emif        afu_if,
  ofs_fim_emif_axi_mm_if.user        mem_if,
  input  logic                       quiesce_req,
  output logic                       quiesce_ack,
  output logic                       proto_err,
  output logic [31:0]                rd_stall_cnt,
  output logic [31:0]                wr_stall_cnt
);
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DRAIN = 2'd1, ST_QUIESCED = 2'd2} state_t;

  localparam logic [7:0] RD_MAX = 8'(MAX_RD_OUTSTANDING);
  localparam logic [7:0] WR_MAX = 8'(MAX_WR_OUTSTANDING);

  state_t             state_r;
  logic [7:0]         rd_cnt_r;
  logic [7:0]         wr_cnt_r;
  logic signed [8:0]  w_bal_r;
  logic               ar_hold_r;
  logic               aw_hold_r;
  logic               w_hold_r;

  logic ar_open_s, aw_open_s, w_open_s;
  logic ar_hs_s, aw_hs_s, w_last_hs_s, w_hs_s, r_last_hs_s, b_hs_s;
  logic rd_uflow_s, wr_uflow_s, idle_s;

  assign afu_if.clk   = mem_if.clk;
  assign afu_if.rst_n = mem_if.rst_n;

  assign mem_if.arid    = afu_if.arid;
  assign mem_if.araddr  = afu_if.araddr;
  assign mem_if.arlen   = afu_if.arlen;
  assign mem_if.aruser  = afu_if.aruser;
  assign mem_if.arvalid = afu_if.arvalid & ar_open_s;
  assign afu_if.arready = mem_if.arready & ar_open_s;

  assign mem_if.awid    = afu_if.awid;
  assign mem_if.awaddr  = afu_if.awaddr;
  assign mem_if.awlen   = afu_if.awlen;
  assign mem_if.awuser  = afu_if.awuser;
  assign mem_if.awvalid = afu_if.awvalid & aw_open_s;
  assign afu_if.awready = mem_if.awready & aw_open_s;

  assign mem_if.wdata   = afu_if.wdata;
  assign mem_if.wstrb   = afu_if.wstrb;
  assign mem_if.wlast   = afu_if.wlast;
  assign mem_if.wvalid  = afu_if.wvalid & w_open_s;
  assign afu_if.wready  = mem_if.wready & w_open_s;

  assign afu_if.rvalid  = mem_if.rvalid;
  assign afu_if.rid     = mem_if.rid;
  assign afu_if.rdata   = mem_if.rdata;
  assign afu_if.rresp   = mem_if.rresp;
  assign afu_if.rlast   = mem_if.rlast;
  assign mem_if.rready  = afu_if.rready;

  assign afu_if.bvalid  = mem_if.bvalid;
  assign afu_if.bid     = mem_if.bid;
  assign afu_if.bresp   = mem_if.bresp;
  assign mem_if.bready  = afu_if.bready;

  // A held request keeps its channel open so valid never drops once presented downstream.
  assign ar_open_s = ((state_r == ST_RUN) && (rd_cnt_r < RD_MAX)) || ar_hold_r;
  assign aw_open_s = ((state_r == ST_RUN) && (wr_cnt_r < WR_MAX)) || aw_hold_r;
  assign w_open_s  = (state_r == ST_RUN) || (w_bal_r > 9'sd0) || w_hold_r;

  assign ar_hs_s     = mem_if.arvalid & mem_if.arready;
  assign aw_hs_s     = mem_if.awvalid & mem_if.awready;
  assign w_hs_s      = mem_if.wvalid & mem_if.wready;
  assign w_last_hs_s = w_hs_s & mem_if.wlast;
  assign r_last_hs_s = mem_if.rvalid & mem_if.rready & mem_if.rlast;
  assign b_hs_s      = mem_if.bvalid & mem_if.bready;

  assign rd_uflow_s = r_last_hs_s & ~ar_hs_s & (rd_cnt_r == 8'd0);
  assign wr_uflow_s = b_hs_s & ~aw_hs_s & (wr_cnt_r == 8'd0);
  assign idle_s     = (rd_cnt_r == 8'd0) && (wr_cnt_r == 8'd0) && (w_bal_r <= 9'sd0) &&
                      !ar_hold_r && !aw_hold_r && !w_hold_r;

  // Outstanding-burst counters; an orphan response floors at zero and latches proto_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_r  <= 8'd0;
      wr_cnt_r  <= 8'd0;
      proto_err <= 1'b0;
    end else begin
      if (ar_hs_s && !r_last_hs_s)                         rd_cnt_r <= rd_cnt_r + 8'd1;
      else if (!ar_hs_s && r_last_hs_s && rd_cnt_r != 8'd0) rd_cnt_r <= rd_cnt_r - 8'd1;
      if (aw_hs_s && !b_hs_s)                              wr_cnt_r <= wr_cnt_r + 8'd1;
      else if (!aw_hs_s && b_hs_s && wr_cnt_r != 8'd0)      wr_cnt_r <= wr_cnt_r - 8'd1;
      if (rd_uflow_s || wr_uflow_s)                        proto_err <= 1'b1;
    end
  end

  // Write address/data balance; negative while W bursts run ahead of their AW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_bal_r <= 9'sd0;
    end else begin
      case ({aw_hs_s, w_last_hs_s})
        2'b10:   w_bal_r <= w_bal_r + 9'sd1;
        2'b01:   w_bal_r <= w_bal_r - 9'sd1;
        default: w_bal_r <= w_bal_r;
      endcase
    end
  end

  // Valid-stability holds: set while presented but not accepted, cleared by the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_hold_r <= 1'b0;
      aw_hold_r <= 1'b0;
      w_hold_r  <= 1'b0;
    end else begin
      ar_hold_r <= ar_hs_s ? 1'b0 : (ar_hold_r | (mem_if.arvalid & ~mem_if.arready));
      aw_hold_r <= aw_hs_s ? 1'b0 : (aw_hold_r | (mem_if.awvalid & ~mem_if.awready));
      w_hold_r  <= w_hs_s  ? 1'b0 : (w_hold_r  | (mem_if.wvalid  & ~mem_if.wready));
    end
  end

  // Quiesce FSM; quiesce_ack is registered alongside the state so it tracks QUIESCED exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_RUN;
      quiesce_ack <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          quiesce_ack <= 1'b0;
          if (quiesce_req) state_r <= ST_DRAIN;
          else             state_r <= ST_RUN;
        end
        ST_DRAIN: begin
          if (!quiesce_req) begin
            state_r     <= ST_RUN;
            quiesce_ack <= 1'b0;
          end else if (idle_s) begin
            state_r     <= ST_QUIESCED;
            quiesce_ack <= 1'b1;
          end else begin
            state_r     <= ST_DRAIN;
            quiesce_ack <= 1'b0;
          end
        end
        ST_QUIESCED: begin
          if (!quiesce_req) begin
            state_r     <= ST_RUN;
            quiesce_ack <= 1'b0;
          end else begin
            state_r     <= ST_QUIESCED;
            quiesce_ack <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_RUN;
          quiesce_ack <= 1'b0;
        end
      endcase
    end
  end

`ifdef OFS_MEM_CREDIT_GATE_STATS_EN
  logic [31:0] rd_stall_r;
  logic [31:0] wr_stall_r;

  // Saturating counts of cycles an upstream request waits on a closed gate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_stall_r <= 32'd0;
      wr_stall_r <= 32'd0;
    end else begin
      if (afu_if.arvalid && !ar_open_s && rd_stall_r != 32'hFFFF_FFFF) rd_stall_r <= rd_stall_r + 32'd1;
      if (afu_if.awvalid && !aw_open_s && wr_stall_r != 32'hFFFF_FFFF) wr_stall_r <= wr_stall_r + 32'd1;
    end
  end

  assign rd_stall_cnt = rd_stall_r;
  assign wr_stall_cnt = wr_stall_r;
`else
  assign rd_stall_cnt = 32'd0;
  assign wr_stall_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_emif_axi_mm_credit_gate.sv
// Directed bench for emif_axi_mm_credit_gate with MAX_RD/MAX_WR = 4.
module tb_emif_axi_mm_credit_gate;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        quiesce_req;
  logic        quiesce_ack;
  logic        proto_err;
  logic [31:0] rd_stall_cnt;
  logic [31:0] wr_stall_cnt;
  int          vectors = 0;
  int          miscompares = 0;
  int          seen;

  ofs_fim_emif_axi_mm_if afu ();
  ofs_fim_emif_axi_mm_if mem ();

  always #5 clk = ~clk;
  assign mem.clk   = clk;
  assign mem.rst_n = rst_n;

  emif_axi_mm_credit_gate #(.MAX_RD_OUTSTANDING(4), .MAX_WR_OUTSTANDING(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .afu_if       (afu),
    .mem_if       (mem),
    .quiesce_req  (quiesce_req),
    .quiesce_ack  (quiesce_ack),
    .proto_err    (proto_err),
    .rd_stall_cnt (rd_stall_cnt),
    .wr_stall_cnt (wr_stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; quiesce_req = 1'b0;
    afu.awvalid = 1'b0; afu.awid = 4'd0; afu.awaddr = 32'd0; afu.awlen = 8'd0; afu.awuser = 4'd0;
    afu.wvalid = 1'b0; afu.wdata = 64'd0; afu.wstrb = 8'hFF; afu.wlast = 1'b0; afu.bready = 1'b0;
    afu.arvalid = 1'b0; afu.arid = 4'd0; afu.araddr = 32'd0; afu.arlen = 8'd0; afu.aruser = 4'd0;
    afu.rready = 1'b0;
    mem.awready = 1'b0; mem.wready = 1'b0; mem.bvalid = 1'b0; mem.bid = 4'd0; mem.bresp = 2'd0;
    mem.arready = 1'b0; mem.rvalid = 1'b0; mem.rid = 4'd0; mem.rdata = 64'd0; mem.rresp = 2'd0;
    mem.rlast = 1'b0;
    repeat (2) tick();
    chk("rst_ack", quiesce_ack, 64'd0);
    chk("rst_proto_err", proto_err, 64'd0);
    chk("rst_rd_stall", rd_stall_cnt, 64'd0);
    chk("rst_rd_cnt", dut.rd_cnt_r, 64'd0);
    rst_n = 1'b1;
    tick();

    // payload pass-through
    afu.araddr = 32'h1234_5678; afu.arid = 4'h3; mem.rdata = 64'hDEAD_BEEF_0BAD_F00D; #1;
    chk("pt_araddr", mem.araddr, 64'h1234_5678);
    chk("pt_arid", mem.arid, 64'h3);
    chk("pt_rdata", afu.rdata, 64'hDEAD_BEEF_0BAD_F00D);

    // six back-to-back ARs, R stalled: only four reach memory
    mem.arready = 1'b1; afu.arvalid = 1'b1; seen = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (mem.arvalid && mem.arready) seen++;
      tick();
    end
    chk("ar_accepted", seen, 64'd4);
    chk("rd_cnt_max", dut.rd_cnt_r, 64'd4);
    chk("ar_gated_full", mem.arvalid, 64'd0);

    // R-last at full count: no accept that cycle, accept with no gap after
    mem.rvalid = 1'b1; mem.rlast = 1'b1; afu.rready = 1'b1; #1;
    chk("ar_ready_at_rlast", afu.arready, 64'd0);
    chk("rvalid_pass", afu.rvalid, 64'd1);
    tick(); #1;
    chk("ar_no_gap", afu.arready, 64'd1);
    tick();
    chk("rd_cnt_ar_and_rlast", dut.rd_cnt_r, 64'd3);
    mem.rvalid = 1'b0;
    tick();
    chk("rd_cnt_refill", dut.rd_cnt_r, 64'd4);
    afu.arvalid = 1'b0; mem.rvalid = 1'b1;
    repeat (4) tick();
    mem.rvalid = 1'b0;
    chk("rd_cnt_drained", dut.rd_cnt_r, 64'd0);

    // request presented with ready low while quiesce rises stays valid and is accepted
    mem.arready = 1'b0; afu.arvalid = 1'b1; quiesce_req = 1'b1; #1;
    chk("hold_presented", mem.arvalid, 64'd1);
    tick(); tick(); #1;
    chk("hold_kept", mem.arvalid, 64'd1);
    chk("hold_no_ack", quiesce_ack, 64'd0);
    mem.arready = 1'b1;
    tick(); #1;
    chk("drain_gated", mem.arvalid, 64'd0);
    afu.arvalid = 1'b0;
    tick();
    chk("drain_no_ack", quiesce_ack, 64'd0);
    mem.rvalid = 1'b1;
    tick();
    mem.rvalid = 1'b0;
    chk("ack_wait_rlast", quiesce_ack, 64'd0);
    tick();
    chk("ack_set", quiesce_ack, 64'd1);
    quiesce_req = 1'b0;
    tick();
    chk("ack_clr", quiesce_ack, 64'd0);

    // W ahead of AW, then quiesce: AW gated, ack anyway, AW passes after release
    afu.wvalid = 1'b1; afu.wlast = 1'b1; mem.wready = 1'b1; #1;
    chk("w_open_run", mem.wvalid, 64'd1);
    tick();
    afu.wvalid = 1'b0;
    chk("w_bal_neg", {55'd0, dut.w_bal_r}, 64'h1FF);
    quiesce_req = 1'b1;
    tick();
    afu.awvalid = 1'b1; mem.awready = 1'b1; #1;
    chk("aw_gated_drain", mem.awvalid, 64'd0);
    tick();
    chk("ack_w_ahead", quiesce_ack, 64'd1);
    chk("aw_gated_quiesced", mem.awvalid, 64'd0);
    afu.wvalid = 1'b1; #1;
    chk("w_gated_quiesced", mem.wvalid, 64'd0);
    afu.wvalid = 1'b0;
    quiesce_req = 1'b0;
    tick(); #1;
    chk("aw_pass_run", mem.awvalid, 64'd1);
    chk("ack_released", quiesce_ack, 64'd0);
    tick();
    afu.awvalid = 1'b0;
    chk("w_bal_zero", {55'd0, dut.w_bal_r}, 64'd0);
    chk("wr_cnt_one", dut.wr_cnt_r, 64'd1);
    mem.bvalid = 1'b1; afu.bready = 1'b1;
    tick();
    mem.bvalid = 1'b0;
    chk("wr_cnt_after_b", dut.wr_cnt_r, 64'd0);
    chk("proto_err_clean", proto_err, 64'd0);

    // orphan B response
    mem.bvalid = 1'b1; #1;
    chk("b_pass", afu.bvalid, 64'd1);
    tick();
    mem.bvalid = 1'b0;
    chk("proto_err_set", proto_err, 64'd1);
    chk("wr_cnt_floor", dut.wr_cnt_r, 64'd0);
    afu.arvalid = 1'b1; mem.arready = 1'b1; #1;
    chk("traffic_unaffected", afu.arready, 64'd1);
    tick();
    afu.arvalid = 1'b0;
    repeat (3) tick();
    chk("proto_err_sticky", proto_err, 64'd1);
    rst_n = 1'b0; #1;
    chk("proto_err_reset", proto_err, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // write credit limit
    afu.awvalid = 1'b1; mem.awready = 1'b1; seen = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (mem.awvalid && mem.awready) seen++;
      tick();
    end
    afu.awvalid = 1'b0;
    chk("aw_accepted", seen, 64'd4);
    chk("wr_cnt_max", dut.wr_cnt_r, 64'd4);

    // stall statistics from a quiesced, idle channel
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; quiesce_req = 1'b1;
    repeat (2) tick();
    chk("quiesced_idle", quiesce_ack, 64'd1);
    afu.arvalid = 1'b1;
    repeat (10) tick();
    afu.arvalid = 1'b0;
    afu.awvalid = 1'b1;
    tick();
    afu.awvalid = 1'b0;
`ifdef OFS_MEM_CREDIT_GATE_STATS_EN
    chk("rd_stall_10", rd_stall_cnt, 64'd10);
    chk("wr_stall_1", wr_stall_cnt, 64'd1);
    dut.rd_stall_r = 32'hFFFF_FFFE;
    afu.arvalid = 1'b1;
    repeat (3) tick();
    afu.arvalid = 1'b0;
    chk("rd_stall_saturate", rd_stall_cnt, 64'hFFFF_FFFF);
`else
    chk("rd_stall_tied", rd_stall_cnt, 64'd0);
    chk("wr_stall_tied", wr_stall_cnt, 64'd0);
`endif
    quiesce_req = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
